// File: rtl/lsu_bank_arbiter_if.sv
// PE-side request/response bundle and bank request/return bus of the LSU bank arbiter.
// The slave modport is the arbiter; the master modport is the PE/bank environment.
interface lsu_bank_arbiter_if #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 4
);
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
    localparam int BUS_W = ADDR_W + DATA_W + 2;

    logic [3:0]          req_valid;
    logic [3:0]          req_we;
    logic [4*ADDR_W-1:0] req_addr;
    logic [4*DATA_W-1:0] req_wdata;
    logic [3:0]          req_ready;
    logic [BUS_W-1:0]    lsu_bus;
    logic [DATA_W:0]     bank_readin_bus;
    logic [3:0]          rsp_valid;
    logic [DATA_W-1:0]   lsu_to_pe;
    logic [CNT_W-1:0]    outstanding;
    logic                err;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, bank_readin_bus,
        output req_ready, lsu_bus, rsp_valid, lsu_to_pe, outstanding, err
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, bank_readin_bus,
        input  req_ready, lsu_bus, rsp_valid, lsu_to_pe, outstanding, err
    );
endinterface

// File: rtl/lsu_bank_arbiter.sv
// Round-robin arbiter sharing one memory-bank port among four PEs, with an in-order
// tag FIFO that routes each bank read return back to the PE that issued the read.
module lsu_bank_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    lsu_bank_arbiter_if.slave  io
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BUS_W = ADDR_W + DATA_W + 2;

    logic [1:0]        r_rr_ptr;
    logic [1:0]        r_tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;
    logic [BUS_W-1:0]  r_lsu_bus_p1;
    logic [3:0]        r_rsp_valid_p1;
    logic [DATA_W-1:0] r_lsu_to_pe_p1;

    logic              w_full;
    logic              w_empty;
    logic [3:0]        w_elig;
    logic [1:0]        w_cand;
    logic [3:0]        w_grant_oh;
    logic [1:0]        w_grant_idx;
    logic              w_grant_any;
    logic              w_grant_we;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [DATA_W-1:0] w_grant_wdata;
    logic [DATA_W-1:0] w_bus_data;
    logic              w_push;
    logic              w_pop;
    logic              w_ret_valid;
    logic [DATA_W-1:0] w_ret_data;
    logic [1:0]        w_pop_tag;

    // Full is taken from the registered count, so a same-cycle pop cannot unblock a read.
    assign w_full      = (r_count == CNT_W'(TAG_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_elig      = io.req_valid & (io.req_we | {4{~w_full}});
    assign w_ret_valid = io.bank_readin_bus[DATA_W];
    assign w_ret_data  = io.bank_readin_bus[DATA_W-1:0];
    assign w_pop_tag   = r_tag_mem[r_rd_ptr];

    always_comb begin
        w_grant_oh  = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        w_cand      = r_rr_ptr;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_rr_ptr + 2'(k);
            if (!w_grant_any && w_elig[w_cand] && rst) begin
                w_grant_any         = 1'b1;
                w_grant_idx         = w_cand;
                w_grant_oh[w_cand]  = 1'b1;
            end
        end
    end

    always_comb begin
        w_grant_we    = 1'b0;
        w_grant_addr  = '0;
        w_grant_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_grant_oh[i]) begin
                w_grant_we    = io.req_we[i];
                w_grant_addr  = io.req_addr[i*ADDR_W +: ADDR_W];
                w_grant_wdata = io.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_bus_data = w_grant_we ? w_grant_wdata : '0;
    assign w_push     = w_grant_any & ~w_grant_we;
    assign w_pop      = w_ret_valid & ~w_empty;

    // Tag storage is plain memory; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= w_grant_idx;
        end
    end

    // Stage p0 -> p1: grant decision and bank return registered onto the output buses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_err          <= 1'b0;
            r_lsu_bus_p1   <= '0;
            r_rsp_valid_p1 <= '0;
            r_lsu_to_pe_p1 <= '0;
        end else begin
            if (w_grant_any) begin
                r_rr_ptr <= w_grant_idx + 2'd1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_ret_valid && w_empty) begin
                r_err <= 1'b1;
            end
            r_lsu_bus_p1   <= w_grant_any ? {1'b1, w_grant_we, w_grant_addr, w_bus_data} : '0;
            r_rsp_valid_p1 <= w_pop ? (4'b0001 << w_pop_tag) : 4'b0000;
            if (w_pop) begin
                r_lsu_to_pe_p1 <= w_ret_data;
            end
        end
    end

    assign io.req_ready   = w_grant_oh;
    assign io.lsu_bus     = r_lsu_bus_p1;
    assign io.rsp_valid   = r_rsp_valid_p1;
    assign io.lsu_to_pe   = r_lsu_to_pe_p1;
    assign io.outstanding = r_count;
    assign io.err         = r_err;
endmodule

// File: tb/tb_lsu_bank_arbiter.sv
// Table-driven bench for lsu_bank_arbiter: each record is one clock cycle of stimulus
// with the grant expected before the edge and the registered outputs expected after it.
module tb_lsu_bank_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lsu_bank_arbiter_if #(.ADDR_W(9), .DATA_W(32), .TAG_DEPTH(4)) bus_if ();

    lsu_bank_arbiter #(.ADDR_W(9), .DATA_W(32), .TAG_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus_if)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [32:0] bank;
        logic [3:0]  ready;
        logic [42:0] bus;
        logic [3:0]  rsp;
        logic [31:0] data;
        logic [2:0]  outs;
        logic        err;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    vec_t tbl[$];

    function automatic vec_t v(logic rst_n, logic [3:0] valid, logic [3:0] we, logic [32:0] bank,
                               logic [3:0] ready, logic [42:0] bus, logic [3:0] rsp,
                               logic [31:0] data, logic [2:0] outs, logic err);
        vec_t r;
        r.rst_n = rst_n; r.valid = valid; r.we = we; r.bank = bank; r.ready = ready;
        r.bus = bus; r.rsp = rsp; r.data = data; r.outs = outs; r.err = err;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int row);
        @(negedge clk);
        rst                    = t.rst_n;
        bus_if.req_valid       = t.valid;
        bus_if.req_we          = t.we;
        bus_if.bank_readin_bus = t.bank;
        #1;
        chk("req_ready", row, 64'(bus_if.req_ready), 64'(t.ready));
        @(posedge clk);
        #1;
        chk("lsu_bus",     row, 64'(bus_if.lsu_bus),     64'(t.bus));
        chk("rsp_valid",   row, 64'(bus_if.rsp_valid),   64'(t.rsp));
        chk("lsu_to_pe",   row, 64'(bus_if.lsu_to_pe),   64'(t.data));
        chk("outstanding", row, 64'(bus_if.outstanding), 64'(t.outs));
        chk("err",         row, 64'(bus_if.err),         64'(t.err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                    = 1'b0;
        bus_if.req_valid       = '0;
        bus_if.req_we          = '0;
        bus_if.bank_readin_bus = '0;
        bus_if.req_addr        = {9'h044, 9'h033, 9'h005, 9'h011};
        bus_if.req_wdata       = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

        // reset, including requests held during reset
        tbl.push_back(v(0, 4'h0, 4'h0, 33'h0, 4'h0, 43'h0, 4'h0, 32'h0, 3'd0, 0));
        tbl.push_back(v(0, 4'hF, 4'hF, 33'h0, 4'h0, 43'h0, 4'h0, 32'h0, 3'd0, 0));
        // single read from PE2 and its return
        tbl.push_back(v(1, 4'h2, 4'h0, 33'h0, 4'h2, 43'h405_0000_0000, 4'h0, 32'h0, 3'd1, 0));
        tbl.push_back(v(1, 4'h0, 4'h0, 33'h0, 4'h0, 43'h0, 4'h0, 32'h0, 3'd1, 0));
        tbl.push_back(v(1, 4'h0, 4'h0, 33'h1DEADBEEF, 4'h0, 43'h0, 4'h2, 32'hDEADBEEF, 3'd0, 0));
        tbl.push_back(v(1, 4'h0, 4'h0, 33'h0, 4'h0, 43'h0, 4'h0, 32'hDEADBEEF, 3'd0, 0));
        // PE4 write brings ptr back to 0, then all four hold writes
        tbl.push_back(v(1, 4'h8, 4'h8, 33'h0, 4'h8, 43'h644_4444_4444, 4'h0, 32'hDEADBEEF, 3'd0, 0));
        tbl.push_back(v(1, 4'hF, 4'hF, 33'h0, 4'h1, 43'h611_1111_1111, 4'h0, 32'hDEADBEEF, 3'd0, 0));
        tbl.push_back(v(1, 4'hF, 4'hF, 33'h0, 4'h2, 43'h605_2222_2222, 4'h0, 32'hDEADBEEF, 3'd0, 0));
        tbl.push_back(v(1, 4'hF, 4'hF, 33'h0, 4'h4, 43'h633_3333_3333, 4'h0, 32'hDEADBEEF, 3'd0, 0));
        tbl.push_back(v(1, 4'hF, 4'hF, 33'h0, 4'h8, 43'h644_4444_4444, 4'h0, 32'hDEADBEEF, 3'd0, 0));
        tbl.push_back(v(1, 4'hF, 4'hF, 33'h0, 4'h1, 43'h611_1111_1111, 4'h0, 32'hDEADBEEF, 3'd0, 0));
        tbl.push_back(v(1, 4'h0, 4'h0, 33'h0, 4'h0, 43'h0, 4'h0, 32'hDEADBEEF, 3'd0, 0));
        // reads PE3, PE1, PE4; PE4 push coincides with first pop
        tbl.push_back(v(1, 4'h4, 4'h0, 33'h0, 4'h4, 43'h433_0000_0000, 4'h0, 32'hDEADBEEF, 3'd1, 0));
        tbl.push_back(v(1, 4'h1, 4'h0, 33'h0, 4'h1, 43'h411_0000_0000, 4'h0, 32'hDEADBEEF, 3'd2, 0));
        tbl.push_back(v(1, 4'h8, 4'h0, 33'h1AAAA0001, 4'h8, 43'h444_0000_0000, 4'h4, 32'hAAAA0001, 3'd2, 0));
        tbl.push_back(v(1, 4'h0, 4'h0, 33'h1BBBB0002, 4'h0, 43'h0, 4'h1, 32'hBBBB0002, 3'd1, 0));
        tbl.push_back(v(1, 4'h0, 4'h0, 33'h1CCCC0003, 4'h0, 43'h0, 4'h8, 32'hCCCC0003, 3'd0, 0));
        tbl.push_back(v(1, 4'h0, 4'h0, 33'h0, 4'h0, 43'h0, 4'h0, 32'hCCCC0003, 3'd0, 0));
        // fill the tag FIFO, stall a fifth read while a write still passes
        tbl.push_back(v(1, 4'hF, 4'h0, 33'h0, 4'h1, 43'h411_0000_0000, 4'h0, 32'hCCCC0003, 3'd1, 0));
        tbl.push_back(v(1, 4'hF, 4'h0, 33'h0, 4'h2, 43'h405_0000_0000, 4'h0, 32'hCCCC0003, 3'd2, 0));
        tbl.push_back(v(1, 4'hF, 4'h0, 33'h0, 4'h4, 43'h433_0000_0000, 4'h0, 32'hCCCC0003, 3'd3, 0));
        tbl.push_back(v(1, 4'hF, 4'h0, 33'h0, 4'h8, 43'h444_0000_0000, 4'h0, 32'hCCCC0003, 3'd4, 0));
        tbl.push_back(v(1, 4'h5, 4'h4, 33'h0, 4'h4, 43'h633_3333_3333, 4'h0, 32'hCCCC0003, 3'd4, 0));
        tbl.push_back(v(1, 4'h1, 4'h0, 33'h1DDDD0004, 4'h0, 43'h0, 4'h1, 32'hDDDD0004, 3'd3, 0));
        tbl.push_back(v(1, 4'h1, 4'h0, 33'h0, 4'h1, 43'h411_0000_0000, 4'h0, 32'hDDDD0004, 3'd4, 0));
        tbl.push_back(v(1, 4'h0, 4'h0, 33'h1EEEE0005, 4'h0, 43'h0, 4'h2, 32'hEEEE0005, 3'd3, 0));
        tbl.push_back(v(1, 4'h0, 4'h0, 33'h1FFFF0006, 4'h0, 43'h0, 4'h4, 32'hFFFF0006, 3'd2, 0));
        tbl.push_back(v(1, 4'h0, 4'h0, 33'h112345678, 4'h0, 43'h0, 4'h8, 32'h12345678, 3'd1, 0));
        tbl.push_back(v(1, 4'h0, 4'h0, 33'h19ABCDEF0, 4'h0, 43'h0, 4'h1, 32'h9ABCDEF0, 3'd0, 0));
        tbl.push_back(v(1, 4'h0, 4'h0, 33'h0, 4'h0, 43'h0, 4'h0, 32'h9ABCDEF0, 3'd0, 0));

        foreach (tbl[i]) apply(tbl[i], i);

        // spurious return sets sticky err; normal traffic keeps working
        apply(v(1, 4'h0, 4'h0, 33'h155555555, 4'h0, 43'h0, 4'h0, 32'h9ABCDEF0, 3'd0, 1), 100);
        apply(v(1, 4'h0, 4'h0, 33'h0, 4'h0, 43'h0, 4'h0, 32'h9ABCDEF0, 3'd0, 1), 101);
        apply(v(1, 4'h1, 4'h0, 33'h0, 4'h1, 43'h411_0000_0000, 4'h0, 32'h9ABCDEF0, 3'd1, 1), 102);
        apply(v(1, 4'h0, 4'h0, 33'h10BADF00D, 4'h0, 43'h0, 4'h1, 32'h0BADF00D, 3'd0, 1), 103);

        // reset with two reads in flight, then a late return
        apply(v(1, 4'h3, 4'h0, 33'h0, 4'h2, 43'h405_0000_0000, 4'h0, 32'h0BADF00D, 3'd1, 1), 200);
        apply(v(1, 4'h3, 4'h0, 33'h0, 4'h1, 43'h411_0000_0000, 4'h0, 32'h0BADF00D, 3'd2, 1), 201);
        apply(v(0, 4'h3, 4'h0, 33'h0, 4'h0, 43'h0, 4'h0, 32'h0, 3'd0, 0), 202);
        apply(v(1, 4'h0, 4'h0, 33'h177777777, 4'h0, 43'h0, 4'h0, 32'h0, 3'd0, 1), 203);
        apply(v(1, 4'h0, 4'h0, 33'h0, 4'h0, 43'h0, 4'h0, 32'h0, 3'd0, 1), 204);
        apply(v(1, 4'hF, 4'hF, 33'h0, 4'h1, 43'h611_1111_1111, 4'h0, 32'h0, 3'd0, 1), 205);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
